// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: req/ack data-memory access with load formatting.
// Optional MEM_MISALIGN_TRAP_EN: trap misaligned accesses instead of issuing them.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_out_data,
    input  logic [31:0] rs2_data,
    output logic        mem_stall,
    output logic        wb_valid,
    output logic [31:0] mem_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        bus_err,
    output logic        misalign
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0] addr_q;
    logic [2:0]  f3_q;
    logic [31:0] rs2_q;
    logic        store_q;
    logic [7:0]  wait_cnt;

    logic        is_load;
    logic        is_store;
    logic        is_mem;
    logic        mis_acc;
    logic        accept;
    logic        pass;
    logic        trap;
    logic        done_ok;
    logic        done_to;
    logic        expire;
    logic [31:0] load_fmt;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign is_mem   = is_load || is_store;
    assign expire   = (wait_cnt == WAIT_LAST);

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q;
    logic mis_half;
    logic mis_word;

    // Halfword and word alignment checks on the incoming address
    always_comb begin
        mis_half = 1'b0;
        mis_word = 1'b0;
        if (funct3 == 3'b001 || (is_load && funct3 == 3'b101))
            mis_half = alu_out_data[0];
        if (funct3 == 3'b010)
            mis_word = (alu_out_data[1:0] != 2'b00);
        mis_acc = mis_half || mis_word;
    end

    assign misalign = misalign_q;
`else
    assign mis_acc  = 1'b0;
    assign misalign = 1'b0;
`endif

    // Next-state and handshake decode
    always_comb begin
        state_next = state;
        mem_stall  = 1'b0;
        accept     = 1'b0;
        pass       = 1'b0;
        trap       = 1'b0;
        done_ok    = 1'b0;
        done_to    = 1'b0;
        unique case (state)
            IDLE: begin
                if (ex_valid) begin
                    if (is_mem && !mis_acc) begin
                        accept     = 1'b1;
                        mem_stall  = 1'b1;
                        state_next = REQ;
                    end else if (is_mem) begin
                        trap = 1'b1;
                    end else begin
                        pass = 1'b1;
                    end
                end
            end
            REQ: begin
                if (dmem_ack) begin
                    done_ok    = 1'b1;
                    state_next = IDLE;
                end else if (expire) begin
                    done_to    = 1'b1;
                    state_next = IDLE;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Lane-select and extend the returned word
    always_comb begin
        ld_byte  = 8'h00;
        ld_half  = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_fmt = dmem_rdata;
        unique case (addr_q[1:0])
            2'b00:   ld_byte = dmem_rdata[7:0];
            2'b01:   ld_byte = dmem_rdata[15:8];
            2'b10:   ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        unique case (f3_q)
            3'b000:  load_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_fmt = {24'h0, ld_byte};
            3'b001:  load_fmt = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_fmt = {16'h0, ld_half};
            default: load_fmt = dmem_rdata;
        endcase
    end

    // Byte enables and replicated write data from the latched store
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = rs2_q;
        unique case (f3_q)
            3'b000: begin
                st_be    = 4'b0001 << addr_q[1:0];
                st_wdata = {4{rs2_q[7:0]}};
            end
            3'b001: begin
                st_be    = 4'b0011 << {addr_q[1], 1'b0};
                st_wdata = {2{rs2_q[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = rs2_q;
            end
        endcase
    end

    assign dmem_req   = (state == REQ);
    assign dmem_we    = dmem_req && store_q;
    assign dmem_addr  = dmem_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign dmem_be    = dmem_req ? st_be : 4'b0000;
    assign dmem_wdata = dmem_req ? st_wdata : 32'h0;

    // Latch the access on acceptance and count unanswered REQ cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= 32'h0;
            f3_q     <= 3'b000;
            rs2_q    <= 32'h0;
            store_q  <= 1'b0;
            wait_cnt <= 8'h00;
        end else if (accept) begin
            addr_q   <= alu_out_data;
            f3_q     <= funct3;
            rs2_q    <= rs2_data;
            store_q  <= is_store;
            wait_cnt <= 8'h00;
        end else if (state == REQ && !dmem_ack) begin
            wait_cnt <= wait_cnt + 8'h01;
        end
    end

    // Writeback result and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
            bus_err  <= 1'b0;
            mem_data <= 32'h0;
        end else begin
            wb_valid <= pass || trap || done_ok || done_to;
            bus_err  <= done_to;
            if (pass || trap || done_to)
                mem_data <= 32'h0;
            else if (done_ok)
                mem_data <= store_q ? 32'h0 : load_fmt;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // One-cycle misalignment trap pulse
    always_ff @(posedge clk) begin
        if (rst)
            misalign_q <= 1'b0;
        else
            misalign_q <= trap;
    end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit.
// Expected WB results are queued at issue and popped on wb_valid.
module tb_mem_access_unit;

    localparam int TO = 6;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ADD   = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] alu_out_data;
    logic [31:0] rs2_data;
    logic        mem_stall;
    logic        wb_valid;
    logic [31:0] mem_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        bus_err;
    logic        misalign;

    typedef struct packed {
        logic [31:0] data;
        logic        berr;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .rst(rst),
        .ex_valid(ex_valid),
        .opcode(opcode),
        .funct3(funct3),
        .alu_out_data(alu_out_data),
        .rs2_data(rs2_data),
        .mem_stall(mem_stall),
        .wb_valid(wb_valid),
        .mem_data(mem_data),
        .dmem_req(dmem_req),
        .dmem_we(dmem_we),
        .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be),
        .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata),
        .bus_err(bus_err),
        .misalign(misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every WB pulse must match the oldest queued result
    always @(negedge clk) begin
        exp_t e;
        if (!rst && wb_valid) begin
            nvec++;
            assert (sb.size() != 0)
            else begin
                nerr++;
                $error("FAIL sb_unexpected_wb observed=%h expected=none",
                       mem_data);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                nvec++;
                assert (mem_data === e.data)
                else begin
                    nerr++;
                    $error("FAIL sb_data observed=%h expected=%h",
                           mem_data, e.data);
                end
                nvec++;
                assert (bus_err === e.berr)
                else begin
                    nerr++;
                    $error("FAIL sb_berr observed=%b expected=%b",
                           bus_err, e.berr);
                end
                nvec++;
                assert (misalign === e.mis)
                else begin
                    nerr++;
                    $error("FAIL sb_mis observed=%b expected=%b",
                           misalign, e.mis);
                end
            end
        end
    end

    // Issue one memory op at posedge+1 and ack it on REQ cycle ack_at
    task automatic run_mem(input logic [6:0] op, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] rd, input int ack_at,
                           output int stalls, output logic [31:0] oaddr,
                           output logic [3:0] obe, output logic [31:0] owd,
                           output logic owe);
        ex_valid     = 1'b1;
        opcode       = op;
        funct3       = f3;
        alu_out_data = a;
        rs2_data     = d;
        #1;
        stalls = mem_stall ? 1 : 0;
        oaddr  = 32'h0;
        obe    = 4'h0;
        owd    = 32'h0;
        owe    = 1'b0;
        tick();
        ex_valid = 1'b0;
        for (int i = 1; i <= ack_at; i++) begin
            if (i == ack_at) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rd;
            end
            #1;
            chk("req_high", 32'(dmem_req), 32'd1);
            if (mem_stall) stalls++;
            oaddr = dmem_addr;
            obe   = dmem_be;
            owd   = dmem_wdata;
            owe   = dmem_we;
            tick();
            dmem_ack = 1'b0;
        end
        #1;
        chk("wb_after_ack", 32'(wb_valid), 32'd1);
        chk("req_low_after_ack", 32'(dmem_req), 32'd0);
    endtask

    initial begin
        int st;
        int cnt;
        logic [31:0] oa;
        logic [3:0]  ob;
        logic [31:0] ow;
        logic        oe;

        rst          = 1'b1;
        ex_valid     = 1'b0;
        opcode       = 7'h0;
        funct3       = 3'h0;
        alu_out_data = 32'h0;
        rs2_data     = 32'h0;
        dmem_ack     = 1'b0;
        dmem_rdata   = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_mem_data", mem_data, 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_addr", dmem_addr, 32'h0);

        // dmem_ack in IDLE must be ignored
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("idle_ack_ignored", 32'(wb_valid), 32'd0);

        // LB / LBU at 0x1003, immediate ack
        sb.push_back('{32'hFFFF_FF80, 1'b0, 1'b0});
        run_mem(OP_LOAD, 3'b000, 32'h1003, 32'h0, 32'h80FF_1234, 1,
                st, oa, ob, ow, oe);
        chk("lb_stalls", st, 1);
        chk("lb_addr", oa, 32'h1000);
        chk("lb_we", 32'(oe), 32'd0);
        tick();
        sb.push_back('{32'h0000_0080, 1'b0, 1'b0});
        run_mem(OP_LOAD, 3'b100, 32'h1003, 32'h0, 32'h80FF_1234, 1,
                st, oa, ob, ow, oe);
        tick();

        // LH upper half, LHU lower half
        sb.push_back('{32'hFFFF_8001, 1'b0, 1'b0});
        run_mem(OP_LOAD, 3'b001, 32'h2002, 32'h0, 32'h8001_7FFF, 2,
                st, oa, ob, ow, oe);
        tick();
        sb.push_back('{32'h0000_7FFF, 1'b0, 1'b0});
        run_mem(OP_LOAD, 3'b101, 32'h2000, 32'h0, 32'h8001_7FFF, 1,
                st, oa, ob, ow, oe);
        tick();

        // SH at 0x2002, ack on the 5th REQ cycle
        sb.push_back('{32'h0, 1'b0, 1'b0});
        run_mem(OP_STORE, 3'b001, 32'h2002, 32'hDEAD_BEEF, 32'h0, 5,
                st, oa, ob, ow, oe);
        chk("sh_stalls", st, 5);
        chk("sh_addr", oa, 32'h2000);
        chk("sh_be", 32'(ob), 32'hC);
        chk("sh_wdata", ow, 32'hBEEF_BEEF);
        chk("sh_we", 32'(oe), 32'd1);
        chk("sh_mem_data", mem_data, 32'h0);
        tick();

        // SB at 0x2005
        sb.push_back('{32'h0, 1'b0, 1'b0});
        run_mem(OP_STORE, 3'b000, 32'h2005, 32'h1122_3344, 32'h0, 2,
                st, oa, ob, ow, oe);
        chk("sb_be", 32'(ob), 32'h2);
        chk("sb_wdata", ow, 32'h4444_4444);
        chk("sb_stalls", st, 2);
        tick();

        // ADD followed directly by LW at 0x10
        sb.push_back('{32'h0, 1'b0, 1'b0});
        ex_valid = 1'b1;
        opcode   = OP_ADD;
        funct3   = 3'b000;
        #1;
        chk("add_no_stall", 32'(mem_stall), 32'd0);
        tick();
        chk("add_wb", 32'(wb_valid), 32'd1);
        sb.push_back('{32'h1234_5678, 1'b0, 1'b0});
        run_mem(OP_LOAD, 3'b010, 32'h10, 32'h0, 32'h1234_5678, 1,
                st, oa, ob, ow, oe);
        chk("lw_data", mem_data, 32'h1234_5678);
        tick();
        chk("hold_wb_low", 32'(wb_valid), 32'd0);
        chk("hold_data", mem_data, 32'h1234_5678);

        // LW with no ack: timeout after TO REQ cycles
        sb.push_back('{32'h0, 1'b1, 1'b0});
        ex_valid     = 1'b1;
        opcode       = OP_LOAD;
        funct3       = 3'b010;
        alu_out_data = 32'h40;
        tick();
        ex_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < TO + 3; i++) begin
            if (dmem_req !== 1'b1) break;
            cnt++;
            tick();
        end
        chk("to_req_cycles", cnt, TO);
        chk("to_bus_err", 32'(bus_err), 32'd1);
        chk("to_wb", 32'(wb_valid), 32'd1);
        chk("to_data", mem_data, 32'h0);
        tick();
        chk("to_berr_pulse", 32'(bus_err), 32'd0);

        // Ack on the last allowed cycle wins over timeout
        sb.push_back('{32'h5A5A_5A5A, 1'b0, 1'b0});
        run_mem(OP_LOAD, 3'b010, 32'h44, 32'h0, 32'h5A5A_5A5A, TO,
                st, oa, ob, ow, oe);
        chk("ack_last_berr", 32'(bus_err), 32'd0);
        chk("ack_last_stalls", st, TO);
        tick();

        // Reset in the middle of a REQ
        ex_valid     = 1'b1;
        opcode       = OP_LOAD;
        funct3       = 3'b010;
        alu_out_data = 32'h50;
        tick();
        ex_valid = 1'b0;
        chk("mid_req_high", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_req_low", 32'(dmem_req), 32'd0);
        chk("rst_no_wb", 32'(wb_valid), 32'd0);
        chk("rst_addr_zero", dmem_addr, 32'h0);
        tick();
        chk("rst_no_wb2", 32'(wb_valid), 32'd0);

        sb.push_back('{32'h0, 1'b0, 1'b0});
        run_mem(OP_STORE, 3'b010, 32'h60, 32'hCAFE_F00D, 32'h0, 2,
                st, oa, ob, ow, oe);
        chk("sw_be", 32'(ob), 32'hF);
        chk("sw_wdata", ow, 32'hCAFE_F00D);
        chk("sw_addr", oa, 32'h60);
        tick();

        // Misaligned LW at 0x3001
`ifdef MEM_MISALIGN_TRAP_EN
        sb.push_back('{32'h0, 1'b0, 1'b1});
        ex_valid     = 1'b1;
        opcode       = OP_LOAD;
        funct3       = 3'b010;
        alu_out_data = 32'h3001;
        #1;
        chk("mis_no_stall", 32'(mem_stall), 32'd0);
        tick();
        ex_valid = 1'b0;
        #1;
        chk("mis_no_req", 32'(dmem_req), 32'd0);
        chk("mis_flag", 32'(misalign), 32'd1);
        chk("mis_wb", 32'(wb_valid), 32'd1);
        tick();
        chk("mis_pulse", 32'(misalign), 32'd0);
`else
        sb.push_back('{32'h89AB_CDEF, 1'b0, 1'b0});
        run_mem(OP_LOAD, 3'b010, 32'h3001, 32'h0, 32'h89AB_CDEF, 1,
                st, oa, ob, ow, oe);
        chk("unal_addr", oa, 32'h3000);
        chk("unal_misalign", 32'(misalign), 32'd0);
        tick();
`endif

        tick();
        chk("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit of the RISC-V pipeline: the producer side of the `mem_data` value consumed by the writeback stage. It takes the EX/MEM effective address, store data and funct3, and runs a req/ack transaction to data memory. It stalls the upstream pipeline until the transaction completes, then presents a lane-aligned, sign- or zero-extended load result with a one-cycle `wb_valid`.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, maximum REQ-state cycles without `dmem_ack` before the access is abandoned (1..255)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX/MEM register holds a valid instruction
- opcode  in  7  instruction opcode; LOAD=0000011, STORE=0100011
- funct3  in  3  access size/sign
- alu_out_data  in  32  effective address
- rs2_data  in  32  store data
- mem_stall  out  1  hold EX/MEM and earlier stages (combinational)
- wb_valid  out  1  one-cycle pulse, result for WB valid
- mem_data  out  32  formatted load data to WB (0 for non-loads)
- dmem_req  out  1  memory request
- dmem_we  out  1  1=write
- dmem_addr  out  32  word address, `{alu_out_data[31:2],2'b00}`
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  memory completes the request this cycle
- dmem_rdata  in  32  read word, valid when `dmem_ack`=1
- bus_err  out  1  one-cycle pulse on timeout
- misalign  out  1  one-cycle pulse on a misaligned access (see Configuration)

## Operation
- States: IDLE, REQ.
- IDLE with `ex_valid` and a non-memory opcode: `mem_stall`=0. Next cycle `wb_valid`=1 and `mem_data`=0.
- IDLE with `ex_valid` and LOAD/STORE: latch address, funct3, rs2 and the load/store flag; go to REQ. `mem_stall`=1.
- REQ: `dmem_req`=1. `dmem_addr`, `dmem_we`, `dmem_be` and `dmem_wdata` are held stable from the latched values. `ex_valid` is ignored.
- REQ with `dmem_ack`=1: `mem_stall`=0 this cycle. Go to IDLE. Next cycle `wb_valid`=1 and `mem_data` holds the formatted `dmem_rdata` (load) or 0 (store).
- Load formatting uses latched `addr[1:0]`:
  - LB (000): byte lane addr[1:0], sign-extend.
  - LBU (100): byte lane addr[1:0], zero-extend.
  - LH (001): halfword `addr[1]`, sign-extend.
  - LHU (101): halfword `addr[1]`, zero-extend.
  - LW (010) and all other funct3 values: full word.
- Store lanes:
  - SB (000): `be=4'b0001<<addr[1:0]`, wdata = byte replicated ×4.
  - SH (001): `be=4'b0011<<{addr[1],1'b0}`, wdata = halfword replicated ×2.
  - SW (010) and all other funct3 values: `be=4'b1111`, wdata = rs2.
- Timeout: a wait counter clears on REQ entry and increments each REQ cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES without ack: `mem_stall`=0 that cycle.
  - Next cycle: `dmem_req`=0, `bus_err`=1, `wb_valid`=1, `mem_data`=0, state IDLE.
- Reset (also mid-REQ): state IDLE, counter 0, and every output low/zero the cycle after `rst` is sampled high. No `wb_valid` is emitted for an aborted access.

## Timing
- Non-memory op: `wb_valid` 1 cycle after acceptance.
- Memory op accepted at cycle T: `dmem_req` high from T+1.
- Ack sampled at cycle A ≥ T+1: `dmem_req` low and `wb_valid`=1 at A+1. Minimum latency is 2 cycles (ack at T+1).
- `mem_stall`=1 from T through A−1; it is low in cycle A, so upstream advances on the edge ending A.
- `wb_valid`, `bus_err` and `misalign` are never high two consecutive cycles for the same instruction.
- `mem_data` holds its last value when `wb_valid`=0.
- Ack in the same cycle as timeout expiry: the ack wins (normal completion, no `bus_err`).
- `dmem_ack` while in IDLE is ignored.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - Misaligned accesses are LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0.
  - A misaligned access is not issued: no REQ, `mem_stall`=0.
  - Next cycle: `misalign`=1, `wb_valid`=1, `mem_data`=0. The store is suppressed.
- MEM_MISALIGN_TRAP_EN undefined:
  - Ignored address bits are dropped: halfword uses `addr[1]` only, word ignores `addr[1:0]`.
  - `misalign` is tied to 0.

## Test plan
- LB at 0x1003, `dmem_rdata`=0x80FF_1234, ack at T+1 → `wb_valid` at T+2, `mem_data`=0xFFFF_FF80. LBU at the same address → 0x0000_0080.
- SH at 0x2002 with rs2=0xDEAD_BEEF → `dmem_addr`=0x2000, `be`=1100, `wdata`=0xBEEF_BEEF, `we`=1. Ack delayed 5 cycles → `mem_stall` high exactly 5 cycles, then `wb_valid`, `mem_data`=0.
- ADD followed by LW at 0x10 with `rdata`=0x1234_5678 and immediate ack → `wb_valid` at T+1 with `mem_data`=0, then `mem_data`=0x1234_5678 two cycles after LW acceptance.
- LW with no ack, TIMEOUT_CYCLES=4 → `dmem_req` high 4 cycles, then `bus_err`=`wb_valid`=1, `mem_data`=0. Ack on the 4th cycle instead → normal completion, `bus_err`=0.
- `rst` asserted during REQ → `dmem_req`=0 the next cycle, no `wb_valid`, state IDLE. A following SW completes normally.
- With MEM_MISALIGN_TRAP_EN, LW at 0x3001 → no `dmem_req`, `misalign`=`wb_valid`=1 next cycle. Without the macro → `dmem_addr`=0x3000, full-word result.
